// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg -- shared IEEE-754 single-precision types and constants.
//   fp32_t     : packed single-precision word {sign, exp[7:0], man[22:0]}
//   FP_ZERO_P  : +0.0
//   FP_ZERO_N  : -0.0
//   FP_QNAN    : canonical quiet NaN produced by the multiplier
//   idx_w()    : width of an index able to address n requesters
// -----------------------------------------------------------------------------
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam logic [31:0] FP_ZERO_P = 32'h00000000;
    localparam logic [31:0] FP_ZERO_N = 32'h80000000;
    localparam logic [31:0] FP_QNAN   = 32'h7FC00000;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_mul_arb_if.sv
// -----------------------------------------------------------------------------
// fp_mul_arb_if -- requester/consumer bundle of the shared FP multiplier.
//   req     : per-requester request, held until granted
//   op_a/b  : per-requester IEEE-754 single operands
//   gnt     : one-hot grant (transfer on req[i] & gnt[i])
//   res_vld : result valid
//   res_id  : index of the requester owning res
//   res     : product
//   res_rdy : consumer accepts res when res_vld & res_rdy
//   busy    : any pipeline stage occupied
// Modports: master (requesters + consumer side), slave (the arbiter).
// -----------------------------------------------------------------------------
interface fp_mul_arb_if #(
    parameter int NREQ = 4
);
    localparam int IDX_W = fp_pkg::idx_w(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0][31:0] op_a;
    logic [NREQ-1:0][31:0] op_b;
    logic [NREQ-1:0]       gnt;
    logic                  res_vld;
    logic [IDX_W-1:0]      res_id;
    logic [31:0]           res;
    logic                  res_rdy;
    logic                  busy;

    modport master (
        output req, op_a, op_b, res_rdy,
        input  gnt, res_vld, res_id, res, busy
    );

    modport slave (
        input  req, op_a, op_b, res_rdy,
        output gnt, res_vld, res_id, res, busy
    );

endinterface

// File: rtl/fp_mul.sv
// -----------------------------------------------------------------------------
// fp_mul -- combinational IEEE-754 single multiplier (team format).
//   a, b : operands
//   p    : product
// Mantissa bits beyond 23 are truncated (no rounding). Denormal operands are
// taken as 0.M x 2^-126. Results below the normal range become truncated
// denormals or signed zero; above it, signed infinity. NaN or inf x 0 gives
// the canonical quiet NaN.
// -----------------------------------------------------------------------------
module fp_mul
    import fp_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t p
);

    // sig carries the hidden bit at [23]; exp_r is the biased exponent that
    // goes with it before range handling.
    function automatic fp32_t pack_trunc(input logic sign, input int exp_r,
                                         input logic [23:0] sig);
        fp32_t r;
        int    sh;
        r.sign = sign;
        if (exp_r >= 255) begin
            r.exp = 8'hFF;
            r.man = '0;
        end else if (exp_r >= 1) begin
            r.exp = 8'(exp_r);
            r.man = sig[22:0];
        end else begin
            sh    = 1 - exp_r;
            r.exp = 8'h00;
            r.man = (sh > 23) ? '0 : 23'(sig >> sh);
        end
        return r;
    endfunction

    logic        sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [23:0] sig_a, sig_b;
    logic [47:0] prod, norm;
    int          exp_a, exp_b, exp_r, lead;

    always_comb begin
        sign   = a.sign ^ b.sign;
        a_zero = (a.exp == 8'h00) && (a.man == '0);
        b_zero = (b.exp == 8'h00) && (b.man == '0);
        a_inf  = (a.exp == 8'hFF) && (a.man == '0);
        b_inf  = (b.exp == 8'hFF) && (b.man == '0);
        a_nan  = (a.exp == 8'hFF) && (a.man != '0);
        b_nan  = (b.exp == 8'hFF) && (b.man != '0);

        sig_a  = {a.exp != 8'h00, a.man};
        sig_b  = {b.exp != 8'h00, b.man};
        exp_a  = (a.exp == 8'h00) ? 1 : int'(a.exp);
        exp_b  = (b.exp == 8'h00) ? 1 : int'(b.exp);
        prod   = 48'(sig_a) * 48'(sig_b);

        // Denormal operands can leave the leading one well below bit 46,
        // so normalise on its actual position.
        lead = 0;
        for (int i = 0; i < 48; i++) begin
            if (prod[i]) lead = i;
        end
        norm  = prod << (47 - lead);
        exp_r = exp_a + exp_b - 127 + (lead - 46);
        p     = pack_trunc(sign, exp_r, norm[47:24]);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p = FP_QNAN;
        end else if (a_inf || b_inf) begin
            p = {sign, 8'hFF, 23'h0};
        end else if (prod == '0) begin
            p = sign ? FP_ZERO_N : FP_ZERO_P;
        end
    end

endmodule

// File: rtl/rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb -- combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index; search runs ptr, ptr+1, ... with wrap
//   gnt : one-hot grant (all-zero when no request)
//   idx : index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arb
    import fp_pkg::*;
#(
    parameter  int NREQ  = 4,
    localparam int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j[IDX_W-1:0]]) begin
                found               = 1'b1;
                gnt[j[IDX_W-1:0]]   = 1'b1;
                idx                 = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_mul_arb.sv
// -----------------------------------------------------------------------------
// fp_mul_arb -- NREQ requesters sharing one FP multiplier via round-robin.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fp_mul_arb_if.slave (req/op_a/op_b/gnt, res_vld/res_id/res/res_rdy,
//           busy)
// Pipeline: S1 (granted operands) -> [S2 (product)] -> SO (result register).
// Transfer in cycle N gives res_vld in N+2, or N+3 with FP_MUL_ARB_PIPE_EN
// defined (adds S2). Each stage loads only when the stage after it is empty
// or emptying, so back-pressure ripples back to gnt without losing entries.
// -----------------------------------------------------------------------------
module fp_mul_arb
    import fp_pkg::*;
#(
    parameter int NREQ = 4
) (
    input logic         clk,
    input logic         rst_n,
    fp_mul_arb_if.slave bus
);

    localparam int IDX_W = idx_w(NREQ);

    logic [IDX_W-1:0] ptr, arb_idx;
    logic [NREQ-1:0]  arb_gnt;
    logic             accept, xfer;

    logic             vld_p1, free_p1;
    fp32_t            a_p1, b_p1, prod_p1;
    logic [IDX_W-1:0] id_p1;

    logic             vld_p3, free_p3;
    fp32_t            res_p3;
    logic [IDX_W-1:0] id_p3;

    logic             so_vld_in;
    fp32_t            so_res_in;
    logic [IDX_W-1:0] so_id_in;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign free_p3 = !vld_p3 || bus.res_rdy;
    assign accept  = free_p1 && rst_n;
    assign bus.gnt = accept ? arb_gnt : '0;
    assign xfer    = |bus.gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + IDX_W'(1);
        end
    end

    // ---- S1: granted operands ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (free_p1) begin
            vld_p1 <= xfer;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            a_p1  <= bus.op_a[arb_idx];
            b_p1  <= bus.op_b[arb_idx];
            id_p1 <= arb_idx;
        end
    end

    fp_mul u_mul (
        .a (a_p1),
        .b (b_p1),
        .p (prod_p1)
    );

`ifdef FP_MUL_ARB_PIPE_EN
    logic             vld_p2, free_p2;
    fp32_t            prod_p2;
    logic [IDX_W-1:0] id_p2;

    assign free_p2 = !vld_p2 || free_p3;
    assign free_p1 = !vld_p1 || free_p2;

    // ---- S2: registered product ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
        end else if (free_p2) begin
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (free_p2 && vld_p1) begin
            prod_p2 <= prod_p1;
            id_p2   <= id_p1;
        end
    end

    assign so_vld_in = vld_p2;
    assign so_res_in = prod_p2;
    assign so_id_in  = id_p2;
    assign bus.busy  = vld_p1 || vld_p2 || vld_p3;
`else
    assign free_p1   = !vld_p1 || free_p3;
    assign so_vld_in = vld_p1;
    assign so_res_in = prod_p1;
    assign so_id_in  = id_p1;
    assign bus.busy  = vld_p1 || vld_p3;
`endif

    // ---- SO: result register, held while the consumer stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p3 <= 1'b0;
            res_p3 <= FP_ZERO_P;
            id_p3  <= '0;
        end else if (free_p3) begin
            vld_p3 <= so_vld_in;
            if (so_vld_in) begin
                res_p3 <= so_res_in;
                id_p3  <= so_id_in;
            end
        end
    end

    assign bus.res_vld = vld_p3;
    assign bus.res     = res_p3;
    assign bus.res_id  = id_p3;

endmodule

// File: tb/tb_fp_mul_arb.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_arb -- scoreboard bench for fp_mul_arb (NREQ = 4).
// Expected products come from a double-precision reference (exact for any
// 24x24-bit significand product) truncated back to single; arbitration is
// modelled as "first requester at or after the pointer". Honors
// FP_MUL_ARB_PIPE_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_fp_mul_arb;

    localparam int NREQ = 4;
`ifdef FP_MUL_ARB_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_mul_arb_if #(.NREQ(NREQ)) bus ();

    fp_mul_arb #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          id;
        int          gcyc;
    } exp_t;

    exp_t            sbq[$];
    int              seen_ids[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              ptr_m = 0;
    logic [NREQ-1:0] xfer_mask = '0;
    logic            pushed_now = 1'b0;
    logic            stall_prev = 1'b0;
    logic [31:0]     res_prev = '0;
    logic [31:0]     id_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic real fp_mag(input logic [31:0] x);
        int e;
        int s;
        e = int'(x[30:23]);
        if (e == 0) begin
            s = int'(x[22:0]);
            e = 1;
        end else begin
            s = int'({1'b1, x[22:0]});
        end
        return real'(s) * (2.0 ** (e - 150));
    endfunction

    function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        real         pr;
        logic [63:0] d;
        logic        s;
        int          e;
        s  = a[31] ^ b[31];
        pr = fp_mag(a) * fp_mag(b);
        if (pr == 0.0) return {s, 31'b0};
        d = $realtobits(pr);
        e = int'(d[62:52]) - 1023 + 127;
        return {s, e[7:0], d[51:29]};
    endfunction

    // Operand pairs whose products stay in the normal single range.
    task automatic rand_pair(output logic [31:0] a, output logic [31:0] b);
        int r;
        r = int'($urandom_range(0, 19));
        a = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
        b = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
        if (r == 0) a = {1'($urandom), 31'b0};
        if (r == 1) begin
            a = {1'($urandom), 8'h00, 23'($urandom) | 23'h1};
            b = {1'($urandom), 8'($urandom_range(200, 250)), 23'($urandom)};
        end
    endtask

    // Grant checker / scoreboard feeder.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_gnt;
        logic            accept_m;
        logic            found;
        int              w;
        int              sel;
        xfer_mask  = '0;
        pushed_now = 1'b0;
        if (!rst_n) begin
            check("gnt_in_reset", 32'(bus.gnt), 32'h0);
        end else begin
            exp_gnt  = '0;
            found    = 1'b0;
            sel      = 0;
            accept_m = (sbq.size() < LAT) || !(bus.res_vld && !bus.res_rdy);
            if (accept_m) begin
                for (int k = 0; k < NREQ; k++) begin
                    w = (ptr_m + k) % NREQ;
                    if (!found && bus.req[w]) begin
                        found        = 1'b1;
                        exp_gnt[w]   = 1'b1;
                        sel          = w;
                    end
                end
            end
            check("gnt", 32'(bus.gnt), 32'(exp_gnt));
            if (found) begin
                sbq.push_back('{res: model_mul(bus.op_a[sel], bus.op_b[sel]),
                                id: sel, gcyc: cyc});
                ptr_m      = (sel + 1) % NREQ;
                pushed_now = 1'b1;
            end
            xfer_mask = bus.req & bus.gnt;
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        int occ;
        #1;
        if (!rst_n) begin
            stall_prev = 1'b0;
            check("res_vld_in_reset", 32'(bus.res_vld), 32'h0);
        end else begin
            occ = sbq.size() - (pushed_now ? 1 : 0);
            check("busy", 32'(bus.busy), 32'(occ != 0));
            if (stall_prev) begin
                check("stall_vld", 32'(bus.res_vld), 32'h1);
                check("stall_res", bus.res, res_prev);
                check("stall_id", 32'(bus.res_id), id_prev);
            end
            if (bus.res_vld) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_res: got res_vld=1 res=%h expected no result", bus.res);
                end else begin
                    check("res", bus.res, sbq[0].res);
                    check("res_id", 32'(bus.res_id), 32'(sbq[0].id));
                    checks++;
                    if (cyc - sbq[0].gcyc < LAT) begin
                        errors++;
                        $display("FAIL early_res: got latency %0d expected >= %0d",
                                 cyc - sbq[0].gcyc, LAT);
                    end
                    if (bus.res_rdy) begin
                        seen_ids.push_back(sbq[0].id);
                        void'(sbq.pop_front());
                    end
                end
            end
            stall_prev = bus.res_vld && !bus.res_rdy;
            res_prev   = bus.res;
            id_prev    = 32'(bus.res_id);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick();
        rst_n = 1'b0;
        sbq.delete();
        ptr_m = 0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq.size() != 0 || bus.busy) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d entries pending expected 0", sbq.size());
        end
    endtask

    // Waits for the next result after a grant seen in cycle g.
    task automatic wait_res(input string name, input int g,
                            input logic [31:0] exp_res, input int exp_id);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            #2;
            if (bus.res_vld) begin
                got = 1'b1;
                check({name, "_lat"}, 32'(cyc - g), 32'(LAT));
                check({name, "_res"}, bus.res, exp_res);
                check({name, "_id"}, 32'(bus.res_id), 32'(exp_id));
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no res_vld expected one within 20 cycles", name);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300us");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g;
        logic [31:0] a, b;
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.op_a    = '0;
        bus.op_b    = '0;
        bus.res_rdy = 1'b1;

        // Reset state, with requests present.
        tick();
        bus.req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            bus.op_a[i] = 32'h3F800000;
            bus.op_b[i] = 32'h40000000;
        end
        @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_vld", 32'(bus.res_vld), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_res", bus.res, 32'h0);
        check("rst_id", 32'(bus.res_id), 32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("first_gnt_idx0", 32'(bus.gnt), 32'h1);
        tick();
        bus.req = '0;
        wait_idle();

        // 3.0 x 2.0 from requester 0.
        bus.req     = 4'b0001;
        bus.op_a[0] = 32'h40400000;
        bus.op_b[0] = 32'h40000000;
        @(negedge clk);
        check("d28_gnt", 32'(bus.gnt), 32'h1);
        g = cyc;
        tick();
        bus.req = '0;
        wait_res("d28", g, 32'h40C00000, 0);
        wait_idle();

        // All four requesting: rotation 0,1,2,3,0.
        apply_reset();
        seen_ids.delete();
        bus.req = 4'b1111;
        for (int i = 0; i < NREQ; i++) rand_pair(bus.op_a[i], bus.op_b[i]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_gnt", 32'(bus.gnt), 32'(1 << (k % 4)));
            tick();
        end
        bus.req = '0;
        wait_idle();
        check("rr_count", 32'(seen_ids.size()), 32'd5);
        for (int k = 0; k < 5 && k < seen_ids.size(); k++)
            check("rr_res_id", 32'(seen_ids[k]), 32'(k % 4));

        // Consumer stall: 1.5 x -2.0 held, pipeline fills behind it.
        bus.res_rdy = 1'b0;
        bus.req     = 4'b0100;
        bus.op_a[2] = 32'h3FC00000;
        bus.op_b[2] = 32'hC0000000;
        @(negedge clk);
        check("stall_gnt", 32'(bus.gnt), 32'h4);
        g = cyc;
        tick();
        bus.req     = 4'b0001;
        bus.op_a[0] = 32'h40000000;
        bus.op_b[0] = 32'h40000000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #2;
            if (cyc - g >= LAT) begin
                check("stall_hold_vld", 32'(bus.res_vld), 32'h1);
                check("stall_hold_res", bus.res, 32'hC0400000);
                check("stall_hold_id", 32'(bus.res_id), 32'h2);
            end
            if (k == 5) check("stall_full_gnt", 32'(bus.gnt), 32'h0);
        end
        tick();
        bus.req     = '0;
        bus.res_rdy = 1'b1;
        wait_idle();

        // Reset while an entry is in flight.
        bus.req     = 4'b0010;
        bus.op_a[1] = 32'h3FC00000;
        bus.op_b[1] = 32'h3FC00000;
        @(negedge clk);
        check("rstmid_gnt", 32'(bus.gnt), 32'h2);
        tick();
        bus.req = '0;
        rst_n   = 1'b0;
        sbq.delete();
        ptr_m   = 0;
        @(negedge clk);
        check("rstmid_busy", 32'(bus.busy), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rstmid_no_vld", 32'(bus.res_vld), 32'h0);
            check("rstmid_idle", 32'(bus.busy), 32'h0);
        end
        tick();
        bus.req = 4'b1111;
        @(negedge clk);
        check("rstmid_ptr0", 32'(bus.gnt), 32'h1);
        tick();
        bus.req = '0;
        wait_idle();

        // Randomised traffic with random back-pressure and dropped requests.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (xfer_mask[i] || !bus.req[i]) begin
                    if ($urandom_range(0, 9) < 6) begin
                        rand_pair(a, b);
                        bus.op_a[i] = a;
                        bus.op_b[i] = b;
                        bus.req[i]  = 1'b1;
                    end else begin
                        bus.req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            bus.res_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.req     = '0;
        bus.res_rdy = 1'b1;
        wait_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
